// File: rtl/scan_pkg.sv
// Shared types and sizes for the slot-scan sequencer.
// The slot count and select width match the 4-to-16 decoder that this block drives.
package scan_pkg;
   localparam int SLOTS = 16;
   localparam int SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/scan_seq_next_slot.sv
// Combinational slot finder. It returns the next set mask bit above the current index,
// the lowest set bit, and a flag that is high when no set bit lies above the current index.
module next_slot
   import scan_pkg::*;
(
   input  logic [SEL_W-1:0] cur,
   input  logic [SLOTS-1:0] mask,
   output logic [SEL_W-1:0] nxt,
   output logic [SEL_W-1:0] lowest,
   output logic             none_above
);

   // Scan from the top down, so the last hit written is the lowest qualifying index.
   always_comb begin
      nxt        = cur;
      lowest     = '0;
      none_above = 1'b1;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            lowest = SEL_W'(i);
         end
         if (mask[i] && (SEL_W'(i) > cur)) begin
            nxt        = SEL_W'(i);
            none_above = 1'b0;
         end
      end
   end

endmodule

// File: rtl/scan_seq.sv
// Slot-scan sequencer. It steps the decoder select and enable through the masked slots
// and holds each slot for Dwell+1 cycles, in single-pass or continuous mode.
module scan_seq
   import scan_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               Start,
   input  logic               Stop,
   input  logic               Single,
   input  logic [SLOTS-1:0]   Mask,
   input  logic [DWELL_W-1:0] Dwell,
   output logic [SEL_W-1:0]   w,
   output logic               En,
   output logic               Busy,
   output logic               Done,
   output logic               Wrap
);

   state_t               state, state_nx;
   logic [SLOTS-1:0]     mask_l;
   logic [DWELL_W-1:0]   dwell_l;
   logic                 single_l;
   logic [DWELL_W-1:0]   cnt;

   logic [SEL_W-1:0]     w_d;
   logic                 en_d, busy_d, done_d, wrap_d, latch;
   logic [DWELL_W-1:0]   cnt_d;

   logic [SLOTS-1:0]     sel_mask;
   logic [SEL_W-1:0]     slot_nxt, slot_low;
   logic                 none_above;
   logic                 cnt_zero;

   // In IDLE the finder looks at the live Mask so the first slot is ready on the Start edge.
   assign sel_mask = (state == IDLE) ? Mask : mask_l;
   assign cnt_zero = (cnt == '0);

   next_slot u_next_slot (
      .cur        (w),
      .mask       (sel_mask),
      .nxt        (slot_nxt),
      .lowest     (slot_low),
      .none_above (none_above)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (Start && (Mask != '0)) begin
               state_nx = SCAN;
            end
         end
         SCAN: begin
            if (Stop) begin
               state_nx = IDLE;
            end else if (cnt_zero && none_above && single_l) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values of the registered outputs; Done and Wrap are single-cycle pulses.
   always_comb begin
      w_d    = w;
      en_d   = En;
      busy_d = Busy;
      cnt_d  = cnt;
      done_d = 1'b0;
      wrap_d = 1'b0;
      latch  = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               if (Mask != '0) begin
                  latch  = 1'b1;
                  w_d    = slot_low;
                  cnt_d  = Dwell;
                  en_d   = 1'b1;
                  busy_d = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         SCAN: begin
            if (Stop) begin
               en_d   = 1'b0;
               busy_d = 1'b0;
            end else if (!cnt_zero) begin
               cnt_d = cnt - DWELL_W'(1);
            end else if (!none_above) begin
               w_d   = slot_nxt;
               cnt_d = dwell_l;
            end else if (single_l) begin
               en_d   = 1'b0;
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               w_d    = slot_low;
               cnt_d  = dwell_l;
               wrap_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         w        <= '0;
         En       <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Wrap     <= 1'b0;
         cnt      <= '0;
         mask_l   <= '0;
         dwell_l  <= '0;
         single_l <= 1'b0;
      end else begin
         w    <= w_d;
         En   <= en_d;
         Busy <= busy_d;
         Done <= done_d;
         Wrap <= wrap_d;
         cnt  <= cnt_d;
         if (latch) begin
            mask_l   <= Mask;
            dwell_l  <= Dwell;
            single_l <= Single;
         end
      end
   end

endmodule
